// File: rtl/dff_shift_ctrl.sv
// dff_shift_ctrl: parallel-load, serial-shift-out controller for a WIDTH-bit
// DFF chain. A word is accepted in IDLE and shifted out MSB first, each bit
// held for CLK_DIV clocks. A one-cycle done pulse follows, then the block
// returns to IDLE. All outputs are registered except start_ready, which is
// decoded from the state register alone.
//
// Handshake: a word transfers on any rising edge where start_valid and
// start_ready are both high. start_ready is high only in IDLE. The producer
// holds start_valid and data_in stable until that edge, and the word is
// sampled only on that edge. abort wins over start_valid in the same cycle.

module dff_shift_ctrl #(
   parameter int WIDTH   = 8,
   parameter int CLK_DIV = 1,
   parameter int CNT_W   = $clog2(WIDTH + 1)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] data_in,
   input  logic             abort,
   output logic             sdo,
   output logic             sdo_valid,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] bit_cnt,
   output logic [1:0]       dbg_state_o
);

   // With CLK_DIV == 1 the divider never counts, but it keeps one bit so
   // that its declaration stays legal.
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sdo_q, sdo_d;
   logic             sdo_valid_q, sdo_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic div_last;
   logic cnt_last;

   assign div_last = (div_q == DIV_W'(CLK_DIV - 1));
   assign cnt_last = (cnt_q == CNT_W'(WIDTH - 1));

   // State register and registered outputs. Reset overrides abort and start.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q     <= S_IDLE;
         sr_q        <= '0;
         div_q       <= '0;
         cnt_q       <= '0;
         sdo_q       <= 1'b0;
         sdo_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         div_q       <= div_d;
         cnt_q       <= cnt_d;
         sdo_q       <= sdo_d;
         sdo_valid_q <= sdo_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Next-state logic. The registered outputs are computed one cycle ahead,
   // so sdo for the next bit comes from sr_q[WIDTH-2] on the shift edge.
   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      div_d       = div_q;
      cnt_d       = cnt_q;
      sdo_d       = sdo_q;
      sdo_valid_d = sdo_valid_q;
      busy_d      = busy_q;
      done_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            sdo_d       = 1'b0;
            sdo_valid_d = 1'b0;
            busy_d      = 1'b0;
            if (start_valid && !abort) begin
               state_d     = S_SHIFT;
               sr_d        = data_in;
               div_d       = '0;
               cnt_d       = '0;
               sdo_d       = data_in[WIDTH-1];
               sdo_valid_d = 1'b1;
               busy_d      = 1'b1;
            end
         end

         S_SHIFT: begin
            if (abort) begin
               state_d     = S_IDLE;
               div_d       = '0;
               sdo_d       = 1'b0;
               sdo_valid_d = 1'b0;
               busy_d      = 1'b0;
            end else if (div_last) begin
               div_d = '0;
               sr_d  = {sr_q[WIDTH-2:0], 1'b0};
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_last) begin
                  state_d     = S_DONE;
                  sdo_d       = 1'b0;
                  sdo_valid_d = 1'b0;
                  done_d      = 1'b1;
               end else begin
                  sdo_d = sr_q[WIDTH-2];
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end

         S_DONE: begin
            // Leaves DONE unconditionally; abort here has the same effect.
            state_d     = S_IDLE;
            div_d       = '0;
            sdo_d       = 1'b0;
            sdo_valid_d = 1'b0;
            busy_d      = 1'b0;
         end

         default: begin
            state_d     = S_IDLE;
            sdo_d       = 1'b0;
            sdo_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   assign start_ready = (state_q == S_IDLE);
   assign sdo         = sdo_q;
   assign sdo_valid   = sdo_valid_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign bit_cnt     = cnt_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dff_shift_ctrl.sv
// Directed bench for dff_shift_ctrl: one instance with CLK_DIV=1 and one
// with CLK_DIV=3. The expected per-cycle output vector for every cycle of a
// transfer is queued when the word is driven and compared as the cycles pass.

module tb_dff_shift_ctrl;

   logic clk;
   logic rst_n;

   logic       sv1, sr1, ab1, sdo1, sdov1, busy1, done1;
   logic [7:0] d1;
   logic [3:0] cnt1;
   logic [1:0] st1;

   logic       sv3, sr3, ab3, sdo3, sdov3, busy3, done3;
   logic [7:0] d3;
   logic [3:0] cnt3;
   logic [1:0] st3;

   // packed vector: {start_ready, busy, done, sdo_valid, sdo, bit_cnt[3:0]}
   logic [8:0] exp_q[$];
   int n_cmp;
   int n_err;

   dff_shift_ctrl #(.WIDTH(8), .CLK_DIV(1)) dut1 (
      .CLK(clk), .RST_N(rst_n), .start_valid(sv1), .start_ready(sr1),
      .data_in(d1), .abort(ab1), .sdo(sdo1), .sdo_valid(sdov1),
      .busy(busy1), .done(done1), .bit_cnt(cnt1), .dbg_state_o(st1)
   );

   dff_shift_ctrl #(.WIDTH(8), .CLK_DIV(3)) dut3 (
      .CLK(clk), .RST_N(rst_n), .start_valid(sv3), .start_ready(sr3),
      .data_in(d3), .abort(ab3), .sdo(sdo3), .sdo_valid(sdov3),
      .busy(busy3), .done(done3), .bit_cnt(cnt3), .dbg_state_o(st3)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [8:0] pack(input logic rdy, input logic bsy,
                                       input logic dn, input logic vld,
                                       input logic s, input logic [3:0] c);
      return {rdy, bsy, dn, vld, s, c};
   endfunction

   // advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // queue the SHIFT cycles and the DONE cycle of one word
   task automatic push_word(input logic [7:0] w, input int div);
      int i;
      for (int j = 0; j < 8 * div; j++) begin
         i = j / div;
         exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 1'b1, w[7 - i], 4'(i)));
      end
      exp_q.push_back(pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd8));
   endtask

   task automatic push_idle(input logic [3:0] c);
      exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, c));
   endtask

   // compare the current cycle of the selected instance against the queue head
   task automatic check_now(input int sel, input string tag);
      logic [8:0] e;
      logic [8:0] o;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $error("FAIL %s: observed empty-queue expected entry", tag);
      end else begin
         e = exp_q.pop_front();
         if (sel == 3) o = {sr3, busy3, done3, sdov3, sdo3, cnt3};
         else          o = {sr1, busy1, done1, sdov1, sdo1, cnt1};
         n_cmp++;
         assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b (rdy,busy,done,vld,sdo,cnt)",
                   tag, o, e);
         end
      end
   endtask

   task automatic check_n(input int n, input int sel, input string tag);
      for (int k = 0; k < n; k++) begin
         check_now(sel, tag);
         step();
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      sv1 = 1'b1; d1 = 8'h5A; ab1 = 1'b0;
      sv3 = 1'b0; d3 = 8'h00; ab3 = 1'b0;

      // reset held for 3 edges with start_valid high
      for (int r = 0; r < 3; r++) begin
         step();
         push_idle(4'd0);
         check_now(1, "reset");
      end
      push_idle(4'd0);
      check_now(3, "reset_div3");

      // first accept on the first edge after release
      rst_n = 1'b1;
      step();
      sv1 = 1'b0;
      push_word(8'h5A, 1);
      push_idle(4'd8);
      check_n(10, 1, "first_5a");

      // 8'hA5, CLK_DIV=1
      sv1 = 1'b1; d1 = 8'hA5;
      step();
      sv1 = 1'b0;
      push_word(8'hA5, 1);
      push_idle(4'd8);
      check_n(10, 1, "word_a5");

      // 8'h81, CLK_DIV=3
      sv3 = 1'b1; d3 = 8'h81;
      step();
      sv3 = 1'b0;
      push_word(8'h81, 3);
      push_idle(4'd8);
      check_n(26, 3, "div3_81");

      // back-to-back with start_valid held: 8'h00 ignored until IDLE
      sv1 = 1'b1; d1 = 8'hFF;
      step();
      d1 = 8'h00;
      push_word(8'hFF, 1);
      push_idle(4'd8);
      check_n(10, 1, "b2b_ff");
      sv1 = 1'b0;
      push_word(8'h00, 1);
      push_idle(4'd8);
      check_n(10, 1, "b2b_00");

      // abort in cycle k+4 of an 8'hA5 shift
      sv1 = 1'b1; d1 = 8'hA5;
      step();
      sv1 = 1'b0;
      for (int i = 0; i < 4; i++)
         exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 1'b1, (8'hA5 >> (7 - i)) & 1'b1, 4'(i)));
      check_n(3, 1, "abort_pre");
      check_now(1, "abort_pre");
      ab1 = 1'b1;
      step();
      ab1 = 1'b0;
      for (int i = 0; i < 3; i++) push_idle(4'd3);
      check_n(3, 1, "abort_post");

      // abort has priority over start in IDLE
      ab1 = 1'b1; sv1 = 1'b1; d1 = 8'hFF;
      step();
      ab1 = 1'b0; sv1 = 1'b0;
      push_idle(4'd3);
      check_now(1, "abort_vs_start");

      // reset in cycle k+3 mid-shift
      sv1 = 1'b1; d1 = 8'hA5;
      step();
      sv1 = 1'b0;
      exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0));
      exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1));
      exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2));
      check_n(2, 1, "rst_pre");
      check_now(1, "rst_pre");
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      push_idle(4'd0);
      check_now(1, "rst_mid");
      step();
      push_idle(4'd0);
      check_now(1, "rst_no_done");

      // normal accept after the mid-shift reset
      sv1 = 1'b1; d1 = 8'h3C;
      step();
      sv1 = 1'b0;
      push_word(8'h3C, 1);
      push_idle(4'd8);
      check_n(10, 1, "after_rst_3c");

      // every queued expectation consumed
      n_cmp++;
      assert (exp_q.size() == 0) else begin
         n_err++;
         $error("FAIL queue_drain: observed %0d left expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dff_shift_ctrl.md
# dff_shift_ctrl

Controller that sequences a WIDTH-bit chain of D flip-flops as a parallel-load, serial-shift-out register. It accepts a parallel word through a valid/ready handshake and shifts the word out MSB first, one bit per CLK_DIV clock periods. It then pulses done and returns to idle. It sits between a parallel producer and any single-bit consumer built from the team's DFF primitives.

## Interface
- WIDTH, default 8: word width in bits; minimum 2.
- CLK_DIV, default 1: clock periods each bit is held on sdo; minimum 1.
- CNT_W, default $clog2(WIDTH+1): width of bit_cnt; derived, do not override.

- CLK  input  1  single clock; all state updates on rising edge.
- RST_N  input  1  reset, synchronous, active-low.
- start_valid  input  1  producer has a word on data_in.
- start_ready  output  1  block is ready to accept a word; high only in IDLE.
- data_in  input  WIDTH  parallel word; sampled only on handshake.
- abort  input  1  synchronous cancel of an in-progress shift.
- sdo  output  1  serial data out, MSB first.
- sdo_valid  output  1  sdo carries a valid bit.
- busy  output  1  high in SHIFT or DONE.
- done  output  1  one-cycle pulse after the last bit completes.
- bit_cnt  output  CNT_W  number of bits fully shifted so far in the current word.

## Operation
- States: IDLE, SHIFT, DONE.
  - Reset values: state=IDLE, shift register=0, sdo=0, sdo_valid=0, busy=0, done=0, bit_cnt=0, divider=0, start_ready=1.
- IDLE:
  - start_ready=1.
  - On start_valid&&start_ready: latch data_in into the shift register, clear bit_cnt and divider, go to SHIFT.
- SHIFT:
  - sdo = shift register MSB; sdo_valid=1; busy=1.
  - The divider counts 0..CLK_DIV-1. At CLK_DIV-1: shift left by one (LSB fills 0), bit_cnt+1, divider back to 0.
  - When bit_cnt reaches WIDTH-1 and the divider reaches CLK_DIV-1: bit_cnt becomes WIDTH, go to DONE.
- DONE:
  - done=1, sdo_valid=0, busy=1, sdo=0.
  - Unconditionally go to IDLE on the next edge; bit_cnt holds WIDTH until the next accept.
- abort:
  - In SHIFT or DONE: go to IDLE next edge, clear sdo, sdo_valid and divider; no done pulse.
  - In IDLE: no effect; abort has priority over start in the same cycle.
- start_valid while not IDLE: ignored; the word is not latched and the producer must hold it.
- RST_N low in any state overrides everything, including abort, on that edge.

## Timing
- Handshake completes at edge k (start_valid&&start_ready).
  - First bit on sdo in cycle k+1.
  - Bit i (0 = MSB) is valid in cycles k+1+i*CLK_DIV through k+(i+1)*CLK_DIV.
- done is high in the single cycle k+WIDTH*CLK_DIV+1.
- start_ready is high again in cycle k+WIDTH*CLK_DIV+2, so the minimum interval between accepts is WIDTH*CLK_DIV+2 cycles.
- Outputs are registered; no combinational path from inputs to outputs. The exception is start_ready, which is decoded from state only.
- bit_cnt updates on the same edge as the shift.

## Test plan
- Reset: hold RST_N=0 for 3 cycles with start_valid=1 -> all outputs at reset values and start_ready=1; first accept occurs on the first edge after RST_N=1.
- WIDTH=8, CLK_DIV=1, data_in=8'hA5 accepted at edge k -> sdo = 1,0,1,0,0,1,0,1 in cycles k+1..k+8 with sdo_valid=1; done=1 only in cycle k+9; bit_cnt=8 in DONE; start_ready=1 in cycle k+10.
- CLK_DIV=3, data_in=8'h81 -> each bit held exactly 3 cycles; sdo high in cycles k+1..k+3 and k+22..k+24; done in cycle k+25.
- Back-to-back: start_valid held high with 8'hFF then 8'h00 -> second word ignored while busy; second accept at edge k+10; sdo all 0s in cycles k+11..k+18.
- abort asserted in cycle k+4 of an 8'hA5 shift -> IDLE at edge k+5, sdo_valid=0 from cycle k+5, no done pulse; start_ready=1 in cycle k+5.
- RST_N=0 asserted in cycle k+3 mid-shift -> every output at its reset value in cycle k+4; no done pulse; a new word is accepted normally afterwards.
